// File: rtl/uart_pkg.sv
// Shared UART definitions: the receiver FSM state encoding and the default bit timing.
// The transmit side imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Pad-side serial input, flag clear and received-word/status bundle of the UART receiver.
// slave is the receiver itself; master is whoever drives the line and consumes the word.
interface uart_rx_deserializer_if #(
  parameter int WORD_LENGTH = 8
);

  logic                   SerialDataIn;
  logic                   clr_rx_flag;
  logic [WORD_LENGTH-1:0] DataRX;
  logic                   rx_flag;
  logic                   parity_error;
  logic                   framing_error;
  logic                   overrun;
  logic                   rx_busy;

  modport slave (
    input  SerialDataIn,
    input  clr_rx_flag,
    output DataRX,
    output rx_flag,
    output parity_error,
    output framing_error,
    output overrun,
    output rx_busy
  );

  modport master (
    output SerialDataIn,
    output clr_rx_flag,
    input  DataRX,
    input  rx_flag,
    input  parity_error,
    input  framing_error,
    input  overrun,
    input  rx_busy
  );

endinterface

// File: rtl/uart_rx_deserializer_rx_shift_reg.sv
// Receive shift register: new bits enter at the MSB and move right,
// so the first (LSB-first) serial bit ends up in bit 0.
module rx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (shift_en) begin
      data_d = {bit_in, data_q[WIDTH-1:1]};
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises the serial line, samples each bit at mid-point and
// publishes complete words with sticky valid/parity/framing/overrun status.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(WORD_LENGTH + 1);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_LENGTH - 1);

  function automatic logic parity_mismatch(input logic [WORD_LENGTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, fall_s;

  uart_state_e            state_d, state_q;
  logic [CNT_W-1:0]       clk_cnt_d, clk_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_d, bit_cnt_q;
  logic                   par_err_d, par_err_q;
  logic [WORD_LENGTH-1:0] data_rx_d, data_rx_q;
  logic                   rx_flag_d, rx_flag_q;
  logic                   parity_error_d, parity_error_q;
  logic                   framing_error_d, framing_error_q;
  logic                   overrun_d, overrun_q;
  logic                   rx_busy_d, rx_busy_q;
  logic                   sh_clr_s, sh_en_s;
  logic [WORD_LENGTH-1:0] shreg_s;

  // Sync flops reset to 1 so an idle line right after reset is not seen as a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.SerialDataIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s   = sync2_q;
  assign fall_s = prev_q & ~sync2_q;

  rx_shift_reg #(
    .WIDTH(WORD_LENGTH)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .clr     (sh_clr_s),
    .shift_en(sh_en_s),
    .bit_in  (rx_s),
    .data_o  (shreg_s)
  );

  always_comb begin
    state_d         = state_q;
    clk_cnt_d       = clk_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    par_err_d       = par_err_q;
    data_rx_d       = data_rx_q;
    rx_flag_d       = rx_flag_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    overrun_d       = overrun_q;
    sh_clr_s        = 1'b0;
    sh_en_s         = 1'b0;

    // Clear is applied first so a flag set later in this block takes priority
    if (bus.clr_rx_flag) begin
      rx_flag_d       = 1'b0;
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
      overrun_d       = 1'b0;
    end else begin
      rx_flag_d       = rx_flag_q;
    end

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (fall_s) begin
          state_d   = START;
          sh_clr_s  = 1'b1;
          par_err_d = 1'b0;
        end else begin
          state_d   = IDLE;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          sh_en_s   = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          par_err_d = parity_mismatch(shreg_s, rx_s);
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) begin
            data_rx_d      = shreg_s;
            rx_flag_d      = 1'b1;
            parity_error_d = par_err_q;
            overrun_d      = rx_flag_q;
          end else begin
            framing_error_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  // FSM, counters and all published status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      par_err_q       <= 1'b0;
      data_rx_q       <= '0;
      rx_flag_q       <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      par_err_q       <= par_err_d;
      data_rx_q       <= data_rx_d;
      rx_flag_q       <= rx_flag_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign bus.DataRX        = data_rx_q;
  assign bus.rx_flag       = rx_flag_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun       = overrun_q;
  assign bus.rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit; dut0 has no parity,
// dut1 expects an even-parity bit.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  uart_rx_deserializer_if #(.WORD_LENGTH(8)) if0 ();
  uart_rx_deserializer_if #(.WORD_LENGTH(8)) if1 ();

  uart_rx_deserializer #(
    .WORD_LENGTH (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1'b0)
  ) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  uart_rx_deserializer #(
    .WORD_LENGTH (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1'b1)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_line(input int sel, input logic b, input int ncyc);
    if (sel == 0) begin
      if0.SerialDataIn = b;
    end else begin
      if1.SerialDataIn = b;
    end
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    drive_line(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, data[i], CPB);
    end
    if (with_par) begin
      drive_line(sel, par_bit, CPB);
    end
    drive_line(sel, stop_bit, CPB);
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) if0.clr_rx_flag = 1'b1;
    else          if1.clr_rx_flag = 1'b1;
    @(posedge clk);
    #1;
    if0.clr_rx_flag = 1'b0;
    if1.clr_rx_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if ({if0.DataRX, if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_dut0: got data=%h flags=%b%b%b%b busy=%b, expected all 0", if0.DataRX,
               if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy);
    end
    vectors++;
    if ({if1.DataRX, if1.rx_flag, if1.parity_error, if1.framing_error, if1.overrun, if1.rx_busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_dut1: got data=%h flags=%b%b%b%b busy=%b, expected all 0", if1.DataRX,
               if1.rx_flag, if1.parity_error, if1.framing_error, if1.overrun, if1.rx_busy);
    end
    drive_line(0, 1'b1, 100);
    vectors++;
    if ({if0.DataRX, if0.rx_flag, if0.framing_error, if0.rx_busy} !== 11'h0) begin
      miscompares++;
      $display("FAIL idle_line: got data=%h flag=%b ferr=%b busy=%b, expected all 0",
               if0.DataRX, if0.rx_flag, if0.framing_error, if0.rx_busy);
    end
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    drive_line(0, 1'b1, 4);
    vectors++;
    if (if0.DataRX !== 8'hA5 || if0.rx_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_rx: got data=%h flag=%b, expected a5 1", if0.DataRX, if0.rx_flag);
    end
    vectors++;
    if ({if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_err: got perr/ferr/ovr/busy=%b%b%b%b, expected 0000",
               if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy);
    end
    pulse_clr(0);
    vectors++;
    if (if0.rx_flag !== 1'b0 || if0.DataRX !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_clr: got flag=%b data=%h, expected 0 a5", if0.rx_flag, if0.DataRX);
    end
  endtask

  task automatic test_glitch();
    drive_line(0, 1'b0, 5);
    drive_line(0, 1'b1, 30);
    vectors++;
    if (if0.rx_busy !== 1'b0 || if0.rx_flag !== 1'b0 || if0.framing_error !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_reject: got busy=%b flag=%b ferr=%b, expected 0 0 0",
               if0.rx_busy, if0.rx_flag, if0.framing_error);
    end
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_line(0, 1'b1, 4);
    vectors++;
    if (if0.DataRX !== 8'h3C || if0.rx_flag !== 1'b1 || if0.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_next: got data=%h flag=%b ovr=%b, expected 3c 1 0",
               if0.DataRX, if0.rx_flag, if0.overrun);
    end
  endtask

  task automatic test_framing();
    pulse_clr(0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (if0.framing_error !== 1'b1 || if0.rx_flag !== 1'b0 || if0.DataRX !== 8'h3C) begin
      miscompares++;
      $display("FAIL framing: got ferr=%b flag=%b data=%h, expected 1 0 3c",
               if0.framing_error, if0.rx_flag, if0.DataRX);
    end
    drive_line(0, 1'b0, 100);
    vectors++;
    if (if0.rx_busy !== 1'b0 || if0.rx_flag !== 1'b0 || if0.framing_error !== 1'b1) begin
      miscompares++;
      $display("FAIL held_low: got busy=%b flag=%b ferr=%b, expected 0 0 1",
               if0.rx_busy, if0.rx_flag, if0.framing_error);
    end
    drive_line(0, 1'b1, 20);
    pulse_clr(0);
    vectors++;
    if (if0.framing_error !== 1'b0 || if0.DataRX !== 8'h3C) begin
      miscompares++;
      $display("FAIL framing_clr: got ferr=%b data=%h, expected 0 3c", if0.framing_error, if0.DataRX);
    end
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    drive_line(1, 1'b1, 4);
    vectors++;
    if (if1.DataRX !== 8'h07 || if1.rx_flag !== 1'b1 || if1.parity_error !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_bad: got data=%h flag=%b perr=%b, expected 07 1 1",
               if1.DataRX, if1.rx_flag, if1.parity_error);
    end
    pulse_clr(1);
    vectors++;
    if (if1.parity_error !== 1'b0 || if1.rx_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_clr: got perr=%b flag=%b, expected 0 0", if1.parity_error, if1.rx_flag);
    end
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    drive_line(1, 1'b1, 4);
    vectors++;
    if (if1.DataRX !== 8'h07 || if1.rx_flag !== 1'b1 || if1.parity_error !== 1'b0 || if1.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_good: got data=%h flag=%b perr=%b ovr=%b, expected 07 1 0 0",
               if1.DataRX, if1.rx_flag, if1.parity_error, if1.overrun);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clr(0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (if0.DataRX !== 8'h11 || if0.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: got data=%h ovr=%b, expected 11 0", if0.DataRX, if0.overrun);
    end
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    drive_line(0, 1'b1, 4);
    vectors++;
    if (if0.DataRX !== 8'h22 || if0.rx_flag !== 1'b1 || if0.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got data=%h flag=%b ovr=%b, expected 22 1 1",
               if0.DataRX, if0.rx_flag, if0.overrun);
    end
    vectors++;
    if (if0.framing_error !== 1'b0 || if0.parity_error !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_err: got ferr=%b perr=%b, expected 0 0", if0.framing_error, if0.parity_error);
    end
  endtask

  task automatic test_reset_midframe();
    // Third frame 0xFF keeps the line high through the data bits, so no new start follows reset
    drive_line(0, 1'b0, CPB);
    drive_line(0, 1'b1, 3 * CPB);
    vectors++;
    if (if0.rx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: got busy=%b, expected 1", if0.rx_busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if ({if0.DataRX, if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL midframe_reset: got data=%h flags=%b%b%b%b busy=%b, expected all 0", if0.DataRX,
               if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy);
    end
    drive_line(0, 1'b1, 6 * CPB);
    vectors++;
    if ({if0.DataRX, if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL midframe_after: got data=%h flags=%b%b%b%b busy=%b, expected all 0", if0.DataRX,
               if0.rx_flag, if0.parity_error, if0.framing_error, if0.overrun, if0.rx_busy);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    if0.SerialDataIn = 1'b1;
    if1.SerialDataIn = 1'b1;
    if0.clr_rx_flag  = 1'b0;
    if1.clr_rx_flag  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
